// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction fetch front-end. It issues one instruction-memory request at a
// time and queues returned words with their PC in a 2-entry FIFO that feeds
// the decode stage.
//
// Ports
//   clk                clock, all state on the rising edge
//   rst                asynchronous active-low reset
//   pc_i / ce_i        fetch address and its valid from the PC stage
//   flush_i            branch redirect: drops queued and in-flight words
//   inst_req_o         memory request strobe (IDLE only)
//   inst_addr_o        memory address, pc_i while requesting else 0
//   inst_gnt_i         memory accepts the request this cycle
//   inst_rvalid_i      read data valid (meaningful in WAIT_DATA only)
//   inst_rdata_i       read instruction word
//   id_valid_o         FIFO head holds a valid instruction
//   id_pc_o            PC of the FIFO head (0 when empty)
//   id_inst_o          instruction word of the FIFO head (0 when empty)
//   id_ready_i         decode consumes the head this cycle
//   fetch_stall_req_o  asks the stall controller to hold the PC
// ---------------------------------------------------------------------------
module if_fetch_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        flush_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_gnt_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i,
  output logic        fetch_stall_req_o
);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_DATA = 1'b1;

  // FSM and outstanding-request bookkeeping
  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [31:0] r_req_pc;
  logic        r_drop;
  logic        w_drop_next;

  // FIFO storage and pointers
  logic [31:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_inst [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [1:0]  w_count_next;

  // Handshake decode
  logic w_in_idle;
  logic w_in_wait;
  logic w_req;
  logic w_fire;
  logic w_resp;
  logic w_push;
  logic w_pop;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_wait = (r_state == ST_WAIT_DATA);

  // Only request when there is guaranteed room for the response; a pending
  // request is the only thing that can raise the count, so count<2 suffices.
  assign w_req  = w_in_idle & ce_i & (r_count != 2'd2) & ~flush_i;
  assign w_fire = w_req & inst_gnt_i;
  assign w_resp = w_in_wait & inst_rvalid_i;

  // A response is discarded if a flush was seen while it was in flight or
  // arrives together with one.
  assign w_push = w_resp & ~r_drop & ~flush_i;
  assign w_pop  = id_valid_o & id_ready_i;

  assign inst_req_o        = w_req;
  assign inst_addr_o       = w_req ? pc_i : 32'd0;
  assign fetch_stall_req_o = ce_i & ~w_fire;

  // Head is driven straight from registers: no same-cycle bypass of rdata.
  assign id_valid_o = (r_count != 2'd0);
  assign id_pc_o    = id_valid_o ? r_fifo_pc[r_rd_ptr]   : 32'd0;
  assign id_inst_o  = id_valid_o ? r_fifo_inst[r_rd_ptr] : 32'd0;

  // Next-state for the FSM and drop flag
  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          w_state_next = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (inst_rvalid_i) begin
          w_state_next = ST_IDLE;
          w_drop_next  = 1'b0;
        end else if (flush_i) begin
          w_drop_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_drop_next  = 1'b0;
      end
    endcase
  end

  // Occupancy next-state; flush overrides any push or pop
  always_comb begin
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + 2'd1;
        2'b01:   w_count_next = r_count - 2'd1;
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_drop   <= 1'b0;
      r_req_pc <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
      if (w_fire) begin
        r_req_pc <= pc_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (flush_i) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_pc[0]   <= 32'd0;
      r_fifo_pc[1]   <= 32'd0;
      r_fifo_inst[0] <= 32'd0;
      r_fifo_inst[1] <= 32'd0;
    end else if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_req_pc;
      r_fifo_inst[r_wr_ptr] <= inst_rdata_i;
    end
  end

endmodule
